// File: rtl/sub_8b_pipe.sv
// sub_8b_pipe: two-stage pipelined 8-bit subtractor (A - B - Bin) with valid/ready handshakes.
// The borrow chain splits at the nibble: low nibble in stage 1, high nibble and flags in stage 2.
module sub_8b_pipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Bin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] D,
    output logic       Bout,
    output logic       V,
    output logic       Z
);
    logic       s1_valid, s2_valid, b4, accept, s2_load;
    logic [3:0] lo, a_hi, b_hi;
    logic [4:0] lo_diff, hi_diff;
    logic [7:0] d_next;
    assign in_ready  = !s1_valid || !s2_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign out_valid = s2_valid;
    // bit 4 of each 5-bit difference is the nibble borrow
    assign lo_diff = {1'b0, A[3:0]} - {1'b0, B[3:0]} - {4'b0, Bin};
    assign hi_diff = {1'b0, a_hi} - {1'b0, b_hi} - {4'b0, b4};
    assign d_next  = {hi_diff[3:0], lo};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            lo       <= '0;
            b4       <= 1'b0;
            a_hi     <= '0;
            b_hi     <= '0;
            D        <= '0;
            Bout     <= 1'b0;
            V        <= 1'b0;
            Z        <= 1'b0;
        end else begin
            s1_valid <= accept || (s1_valid && !s2_load);
            s2_valid <= s2_load || (s2_valid && !out_ready);
            if (accept) begin
                lo   <= lo_diff[3:0];
                b4   <= lo_diff[4];
                a_hi <= A[7:4];
                b_hi <= B[7:4];
            end
            if (s2_load) begin
                D    <= d_next;
                Bout <= hi_diff[4];
                V    <= (a_hi[3] != b_hi[3]) && (d_next[7] != a_hi[3]);
                Z    <= d_next == 8'h00;
            end
        end
    end
endmodule

// File: tb/tb_sub_8b_pipe.sv
// tb_sub_8b_pipe: table-driven and scoreboard bench for sub_8b_pipe.
// Expected results are queued on input handshake and compared on output handshake.
module tb_sub_8b_pipe;
    logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, Bin = 1'b0;
    logic [7:0] A = '0, B = '0;
    logic       in_ready, out_valid, Bout, V, Z;
    logic [7:0] D;

    typedef struct packed {logic [7:0] d; logic bout; logic v; logic z;} res_t;
    typedef struct {logic [7:0] a; logic [7:0] b; logic bin; res_t r;} vec_t;

    res_t q[$];
    res_t pend;
    int   errors = 0, checks = 0, cyc = 0, npop = 0, last_pop = 0;

    sub_8b_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
        .D(D), .Bout(Bout), .V(V), .Z(Z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
        logic [8:0] full;
        res_t r;
        full   = {1'b0, a} - {1'b0, b} - {8'b0, bin};
        r.d    = full[7:0];
        r.bout = full[8];
        r.v    = (a[7] != b[7]) && (full[7] != a[7]);
        r.z    = full[7:0] == 8'h00;
        return r;
    endfunction

    function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic bin,
                                input logic [7:0] d, input logic bo, input logic v, input logic z);
        vec_t t;
        t.a = a; t.b = b; t.bin = bin;
        t.r.d = d; t.r.bout = bo; t.r.v = v; t.r.z = z;
        return t;
    endfunction

    function automatic vec_t rnd();
        vec_t t;
        t.a   = 8'($urandom_range(0, 255));
        t.b   = 8'($urandom_range(0, 255));
        t.bin = 1'($urandom_range(0, 1));
        t.r   = model(t.a, t.b, t.bin);
        return t;
    endfunction

    // scoreboard monitor: sampled mid-cycle, handshakes complete on the next rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("spurious output", 32'(q.size()), 1);
                else check("result {D,Bout,V,Z}", 32'({D, Bout, V, Z}), 32'(q.pop_front()));
                npop++;
                last_pop = cyc;
            end
            if (in_valid && in_ready) q.push_back(pend);
        end
    end

    // called just after a rising edge; returns just after the edge that accepted the beat
    task automatic send(input vec_t t);
        int  n = 0;
        logic acc = 1'b0;
        A = t.a; B = t.b; Bin = t.bin; pend = t.r; in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) check("accept timeout", 32'(acc), 1);
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain leftover", 32'(q.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t tbl[10];
        vec_t bp[4];
        res_t snap;
        int   c0;
        tbl[0] = mk(8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
        tbl[2] = mk(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        tbl[3] = mk(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        tbl[4] = mk(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        tbl[5] = mk(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
        tbl[6] = mk(8'h42, 8'h42, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tbl[7] = mk(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        tbl[8] = mk(8'h0F, 8'h0F, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        tbl[9] = mk(8'h01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);

        #12;
        check("reset out_valid", 32'(out_valid), 0);
        check("reset in_ready", 32'(in_ready), 1);
        check("reset D,Bout,V,Z", 32'({D, Bout, V, Z}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("in_ready after reset", 32'(in_ready), 1);

        // first beat latency: valid one edge after the accepting edge
        out_ready = 1'b1;
        send(tbl[0]);
        in_valid = 1'b0;
        @(negedge clk);
        check("latency out_valid early", 32'(out_valid), 0);
        @(negedge clk);
        check("latency out_valid on time", 32'(out_valid), 1);
        @(posedge clk); #1;
        drain();

        for (int i = 1; i < 10; i++) send(tbl[i]);
        drain();

        // backpressure: two accepts fill the pipe, then outputs must hold
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) bp[i] = rnd();
        send(bp[0]);
        send(bp[1]);
        A = bp[2].a; B = bp[2].b; Bin = bp[2].bin; pend = bp[2].r; in_valid = 1'b1;
        @(negedge clk);
        check("full in_ready", 32'(in_ready), 0);
        check("full out_valid", 32'(out_valid), 1);
        snap = {D, Bout, V, Z};
        check("held output", 32'(snap), 32'(bp[0].r));
        @(negedge clk);
        @(negedge clk);
        check("stable under stall", 32'({D, Bout, V, Z}), 32'(snap));
        check("still full in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        c0 = npop;
        send(bp[2]);
        send(bp[3]);
        drain();
        check("backpressure pops", 32'(npop - c0), 4);

        // full throughput
        c0 = cyc;
        npop = 0;
        for (int i = 0; i < 256; i++) send(rnd());
        drain();
        check("throughput count", 32'(npop), 256);
        check("throughput last pop cycle", 32'(last_pop - c0), 257);

        // reset with two beats in flight
        send(rnd());
        send(rnd());
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async reset out_valid", 32'(out_valid), 0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(tbl[5]);
        in_valid = 1'b0;
        @(negedge clk);
        check("post-reset early", 32'(out_valid), 0);
        @(negedge clk);
        check("post-reset on time", 32'(out_valid), 1);
        @(posedge clk); #1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
